// File: rtl/mux2_arbiter_4b.sv
// Two-requester round-robin arbiter feeding a 4-bit 2:1 mux into a one-entry
// output buffer; all ports use val/rdy handshakes.
module mux2_arbiter_4b #(
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in0_val,
  output logic       in0_rdy,
  input  logic [3:0] in0_msg,
  input  logic       in1_val,
  output logic       in1_rdy,
  input  logic [3:0] in1_msg,
  output logic       out_val,
  input  logic       out_rdy,
  output logic [3:0] out_msg,
  output logic       out_src
);

  // Handshake: a message moves across a port on a rising edge exactly when
  // that port's val and rdy are both high; senders hold val/msg until then.

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  buf_state_t state;
  logic       prio;
  logic       can_load;
  logic       grant;
  logic [3:0] mux_msg;
  logic       load;

  assign out_val  = (state == FULL);
  assign can_load = !out_val || out_rdy;

  always_comb begin
    grant = prio;
    if (in0_val && !in1_val) begin
      grant = 1'b0;
    end else if (in1_val && !in0_val) begin
      grant = 1'b1;
    end
  end

  assign mux_msg = grant ? in1_msg : in0_msg;

  // Ready is suppressed during reset so no transfer is seen by a requester.
  assign in0_rdy = !reset && can_load && in0_val && (grant == 1'b0);
  assign in1_rdy = !reset && can_load && in1_val && (grant == 1'b1);
  assign load    = in0_rdy || in1_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      out_msg <= 4'b0000;
      out_src <= 1'b0;
      prio    <= RESET_PRIO;
    end else if (load) begin
      state   <= FULL;
      out_msg <= mux_msg;
      out_src <= grant;
      prio    <= ~grant;
    end else if (out_val && out_rdy) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_mux2_arbiter_4b.sv
// Directed bench for mux2_arbiter_4b: a transaction-level reference model
// checked every cycle, plus literal expectations for the documented scenarios.
module tb_mux2_arbiter_4b;

  logic       clk;
  logic       reset;
  logic       in0_val;
  logic       in0_rdy;
  logic [3:0] in0_msg;
  logic       in1_val;
  logic       in1_rdy;
  logic [3:0] in1_msg;
  logic       out_val;
  logic       out_rdy;
  logic [3:0] out_msg;
  logic       out_src;

  int checks = 0;
  int errors = 0;

  mux2_arbiter_4b #(.RESET_PRIO(1'b0)) dut (
    .clk     (clk),
    .reset   (reset),
    .in0_val (in0_val),
    .in0_rdy (in0_rdy),
    .in0_msg (in0_msg),
    .in1_val (in1_val),
    .in1_rdy (in1_rdy),
    .in1_msg (in1_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .out_src (out_src)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: buffer contents plus the tie-break owner
  logic       model_live = 1'b0;
  logic       m_full;
  logic [3:0] m_msg;
  logic       m_src;
  logic       m_prio;

  // Which requester transfers this cycle: 0, 1, or 2 for nobody.
  function automatic int winner();
    if (reset) return 2;
    if (m_full && !out_rdy) return 2;
    if (in0_val && in1_val) return m_prio ? 1 : 0;
    if (in0_val) return 0;
    if (in1_val) return 1;
    return 2;
  endfunction

  always @(posedge clk) begin
    int w;
    w = winner();
    if (reset) begin
      m_full     = 1'b0;
      m_msg      = 4'b0000;
      m_src      = 1'b0;
      m_prio     = 1'b0;
      model_live = 1'b1;
    end else if (w != 2) begin
      m_full = 1'b1;
      m_msg  = (w == 1) ? in1_msg : in0_msg;
      m_src  = (w == 1);
      m_prio = (w == 0);
    end else if (m_full && out_rdy) begin
      m_full = 1'b0;
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: every cycle once the model has seen a reset
  always @(negedge clk) begin
    if (model_live) begin
      int w;
      w = winner();
      check("cmp_out_val", {3'b0, out_val}, {3'b0, m_full});
      if (m_full) begin
        check("cmp_out_msg", out_msg, m_msg);
        check("cmp_out_src", {3'b0, out_src}, {3'b0, m_src});
      end
      check("cmp_in0_rdy", {3'b0, in0_rdy}, {3'b0, w == 0});
      check("cmp_in1_rdy", {3'b0, in1_rdy}, {3'b0, w == 1});
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drive(input logic v0, input logic [3:0] m0,
                       input logic v1, input logic [3:0] m1, input logic ordy);
    in0_val = v0;
    in0_msg = m0;
    in1_val = v1;
    in1_msg = m1;
    out_rdy = ordy;
  endtask

  logic [3:0] rr_msg [4];
  logic       rr_src [4];

  initial begin
    rr_msg[0] = 4'b1100; rr_src[0] = 1'b0;
    rr_msg[1] = 4'b0011; rr_src[1] = 1'b1;
    rr_msg[2] = 4'b1100; rr_src[2] = 1'b0;
    rr_msg[3] = 4'b0011; rr_src[3] = 1'b1;

    // reset with requester 0 valid
    reset = 1'b1;
    drive(1'b1, 4'b0111, 1'b0, 4'b0000, 1'b0);
    tick();
    settle();
    check("reset_in0_rdy", {3'b0, in0_rdy}, 4'd0);
    check("reset_in1_rdy", {3'b0, in1_rdy}, 4'd0);
    check("reset_out_val", {3'b0, out_val}, 4'd0);
    check("reset_out_msg", out_msg, 4'b0000);
    check("reset_out_src", {3'b0, out_src}, 4'd0);

    // single requester 1
    reset = 1'b0;
    drive(1'b0, 4'b0111, 1'b1, 4'b1010, 1'b1);
    settle();
    check("single_in1_rdy", {3'b0, in1_rdy}, 4'd1);
    check("single_in0_rdy", {3'b0, in0_rdy}, 4'd0);
    tick();
    drive(1'b1, 4'b1100, 1'b1, 4'b0011, 1'b1);
    settle();
    check("single_out_val", {3'b0, out_val}, 4'd1);
    check("single_out_msg", out_msg, 4'b1010);
    check("single_out_src", {3'b0, out_src}, 4'd1);
    check("single_prio0_in0_rdy", {3'b0, in0_rdy}, 4'd1);

    // contention round robin
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) drive(1'b1, 4'b0101, 1'b0, 4'b0011, 1'b1);
      settle();
      check("rr_out_val", {3'b0, out_val}, 4'd1);
      check("rr_out_msg", out_msg, rr_msg[i]);
      check("rr_out_src", {3'b0, out_src}, {3'b0, rr_src[i]});
    end

    // backpressure with 0101 buffered, requester 1 then owns ties
    tick();
    drive(1'b1, 4'b1100, 1'b1, 4'b0011, 1'b0);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bp_in0_rdy", {3'b0, in0_rdy}, 4'd0);
      check("bp_in1_rdy", {3'b0, in1_rdy}, 4'd0);
      check("bp_out_msg", out_msg, 4'b0101);
      check("bp_out_val", {3'b0, out_val}, 4'd1);
      tick();
    end
    out_rdy = 1'b1;
    settle();
    check("bp_release_in1_rdy", {3'b0, in1_rdy}, 4'd1);
    tick();
    drive(1'b0, 4'b1100, 1'b0, 4'b0011, 1'b1);
    settle();
    check("bp_no_bubble_val", {3'b0, out_val}, 4'd1);
    check("bp_no_bubble_msg", out_msg, 4'b0011);

    // drain to empty, prio stays with requester 0
    tick();
    settle();
    check("drain_out_val", {3'b0, out_val}, 4'd0);
    check("drain_out_msg_hold", out_msg, 4'b0011);
    drive(1'b1, 4'b1111, 1'b1, 4'b0011, 1'b1);
    settle();
    check("drain_prio_in0_rdy", {3'b0, in0_rdy}, 4'd1);

    // load 1111 from requester 0 (prio -> 1), then reset mid-operation
    in1_val = 1'b0;
    tick();
    drive(1'b1, 4'b1111, 1'b1, 4'b0011, 1'b0);
    reset = 1'b1;
    settle();
    check("midrst_out_msg", out_msg, 4'b1111);
    check("midrst_in0_rdy", {3'b0, in0_rdy}, 4'd0);
    check("midrst_in1_rdy", {3'b0, in1_rdy}, 4'd0);
    tick();
    reset = 1'b0;
    out_rdy = 1'b1;
    settle();
    check("midrst_out_val", {3'b0, out_val}, 4'd0);
    check("midrst_in0_rdy_after", {3'b0, in0_rdy}, 4'd1);
    check("midrst_in1_rdy_after", {3'b0, in1_rdy}, 4'd0);
    tick();
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    settle();
    check("midrst_first_src", {3'b0, out_src}, 4'd0);
    check("midrst_first_msg", out_msg, 4'b1111);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux2_arbiter_4b.md
# mux2_arbiter_4b

Round-robin arbiter and output stage that shares the calculator's 4-bit 2:1 mux datapath between two requesters (operand/result sources). It resolves contention with a single priority pointer, drives the mux select from the grant, and registers the winning 4-bit message in a one-entry output buffer. All ports use latency-insensitive val/rdy handshakes, and the buffer sustains one message per cycle.

## Interface
- `RESET_PRIO`, default 0: requester that holds priority after reset (0 or 1).
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `in0_val` input, 1 bit: requester 0 has a valid message.
- `in0_rdy` output, 1 bit: requester 0 message is accepted this cycle.
- `in0_msg` input, 4 bits: requester 0 data (mux in0).
- `in1_val` input, 1 bit: requester 1 has a valid message.
- `in1_rdy` output, 1 bit: requester 1 message is accepted this cycle.
- `in1_msg` input, 4 bits: requester 1 data (mux in1).
- `out_val` output, 1 bit: output buffer holds a valid message.
- `out_rdy` input, 1 bit: consumer accepts the output message.
- `out_msg` output, 4 bits: buffered message.
- `out_src` output, 1 bit: requester that produced `out_msg`.

## Operation
- **State:**
  - Output buffer: `out_val`, `out_msg`, `out_src`.
  - Priority pointer `prio`, 1 bit: the requester that wins a tie.
  - Buffer states: EMPTY (`out_val`=0) and FULL (`out_val`=1).
- **Combinational control:**
  - `can_load = !out_val || out_rdy`, so the buffer can be refilled in the same cycle it drains.
  - `grant`:
    - both valid: `grant = prio`;
    - only `in0_val`: `grant = 0`;
    - only `in1_val`: `grant = 1`;
    - neither valid: `grant = prio` (don't-care).
  - Mux select equals `grant`.
  - `in0_rdy = can_load && in0_val && grant==0`; `in1_rdy = can_load && in1_val && grant==1`.
  - `in0_rdy` and `in1_rdy` are never both 1.
- **Load:** on a rising edge with `inK_val && inK_rdy`:
  - `out_msg <= inK_msg`, `out_src <= K`, `out_val <= 1`;
  - `prio <= ~K`, so the loser of this cycle wins the next tie.
- **Drain:** on a rising edge with `out_val && out_rdy` and no load, `out_val <= 0`. `out_msg` and `out_src` hold their last values.
- **Drain and load together:** the buffer stays FULL with the new message. No bubble.
- **No transfer:** `prio` is unchanged. A lone requester winning does update `prio`.
- **Stall:** while `out_val && !out_rdy`, `out_msg` and `out_src` hold stable and both input `rdy` signals are 0.
- **Reset:** while `reset`=1, `in0_rdy` and `in1_rdy` are forced to 0. On the edge:
  - `out_val`=0, `out_msg`=0, `out_src`=0, `prio`=`RESET_PRIO`;
  - a buffered message is discarded.
- **Width:** messages pass through unmodified, 4 bits. No arithmetic.

## Timing
- **Latency:** 1 cycle. A message accepted at edge N appears on `out_val`/`out_msg` after edge N, in cycle N+1.
- **Throughput:** 1 message per cycle when `out_rdy` is held high.
- **Fairness:** under continuous contention, grants alternate 0,1,0,1…. Neither requester waits more than 1 grant.
- **Combinational paths:**
  - `inK_rdy` depends combinationally on `in0_val`, `in1_val`, `out_val`, `out_rdy`, and `prio`.
  - `out_*` are registered only; no combinational input-to-output path.
- **Handshake rules:**
  - Transfer occurs only when `val` and `rdy` are both high at the rising edge.
  - A requester must hold `val` and `msg` until accepted.

## Test plan
- **Reset:**
  - Stimulus: assert `reset` with `in0_val`=1.
  - Required response: `in0_rdy`=0 and `in1_rdy`=0; after the edge, `out_val`=0, `out_msg`=0000, `out_src`=0.
- **Single requester:**
  - Stimulus: `in1_val`=1, `in1_msg`=1010, `out_rdy`=1.
  - Required response: `in1_rdy`=1, `in0_rdy`=0; next cycle `out_val`=1, `out_msg`=1010, `out_src`=1; `prio` becomes 0.
- **Contention round-robin (`RESET_PRIO`=0):**
  - Stimulus: both valid for 4 cycles, `in0_msg`=1100, `in1_msg`=0011, `out_rdy`=1.
  - Required response: output sequence 1100/0, 0011/1, 1100/0, 0011/1, one per cycle.
- **Backpressure:**
  - Stimulus: buffer FULL with 0101, `out_rdy`=0 for 3 cycles, both inputs valid.
  - Required response: both `rdy` signals 0 and `out_msg` stable at 0101. When `out_rdy` rises, drain and load occur in the same edge with no empty cycle.
- **Drain to empty:**
  - Stimulus: buffer FULL, `out_rdy`=1, no input valid.
  - Required response: `out_val`=0 next cycle; `prio` unchanged.
- **Reset mid-operation:**
  - Stimulus: buffer FULL with 1111, `prio`=1; assert `reset` for 1 cycle.
  - Required response: `out_val`=0 and `prio`=0. With both inputs then valid, requester 0 is granted first.
